// File: rtl/fifo_pkg.sv
// Shared defaults, depth derivation and flag encoding for the parameterised FIFO.
package fifo_pkg;

  localparam int unsigned FIFO_DEF_DATA_WIDTH = 32;
  localparam int unsigned FIFO_DEF_PTR_WIDTH  = 2;
  localparam int unsigned FIFO_DEF_AE_LEVEL   = 1;

  localparam int unsigned FIFO_OUT_FALLTHRU   = 0;
  localparam int unsigned FIFO_OUT_REGISTERED = 1;

  typedef struct packed {
    logic empty;
    logic full;
    logic almost_empty;
    logic almost_full;
  } fifo_flags_t;

  function automatic int unsigned fifo_depth(input int unsigned ptr_width);
    return 32'd1 << ptr_width;
  endfunction

  function automatic logic fifo_params_ok(input int unsigned ptr_width,
                                          input int unsigned ae_level,
                                          input int unsigned af_level);
    return (ptr_width >= 1) && (ae_level < af_level) &&
           (af_level <= fifo_depth(ptr_width));
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping FIFO pointer, one extra MSB so full and empty can be told apart.
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int unsigned PTR_WIDTH = FIFO_DEF_PTR_WIDTH
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 clr_i,
  input  logic                 inc_i,
  output logic [PTR_WIDTH:0]   ptr_o
);

  logic [PTR_WIDTH:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = ptr_q + (PTR_WIDTH+1)'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_buffer_param.sv
// Parameterised synchronous FIFO with level flags, sticky error flags and
// optional registered output stage.
module fifo_buffer_param
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FIFO_DEF_DATA_WIDTH,
  parameter int unsigned PTR_WIDTH  = FIFO_DEF_PTR_WIDTH,
  parameter int unsigned AF_LEVEL   = fifo_depth(PTR_WIDTH) - 1,
  parameter int unsigned AE_LEVEL   = FIFO_DEF_AE_LEVEL,
  parameter int unsigned OUT_REG    = FIFO_OUT_FALLTHRU
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  CLR,
  input  logic                  FIFO_WRITE,
  input  logic                  FIFO_READ,
  input  logic [DATA_WIDTH-1:0] DATA_IN,
  output logic [DATA_WIDTH-1:0] DATA_OUT,
  output logic                  DOUT_VALID,
  output logic                  EMPTY,
  output logic                  FULL,
  output logic                  ALMOST_EMPTY,
  output logic                  ALMOST_FULL,
  output logic [PTR_WIDTH:0]    LEVEL,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW
);

  localparam int unsigned DEPTH = fifo_depth(PTR_WIDTH);
  localparam logic [PTR_WIDTH:0] AF_LVL = (PTR_WIDTH+1)'(AF_LEVEL);
  localparam logic [PTR_WIDTH:0] AE_LVL = (PTR_WIDTH+1)'(AE_LEVEL);

  if (!fifo_params_ok(PTR_WIDTH, AE_LEVEL, AF_LEVEL)) begin : g_param_err
    $error("fifo_buffer_param: need PTR_WIDTH>=1 and AE_LEVEL < AF_LEVEL <= depth");
  end

  logic [PTR_WIDTH:0]    wr_ptr, rd_ptr, level;
  fifo_flags_t           flags;
  logic                  wr_en, rd_en;
  logic                  ovf_q, ovf_d, unf_q, unf_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_word;

  // Flags depend only on registered pointers, never on the request inputs.
  assign level = wr_ptr - rd_ptr;

  always_comb begin
    flags.empty        = (wr_ptr == rd_ptr);
    flags.full         = (wr_ptr[PTR_WIDTH] != rd_ptr[PTR_WIDTH]) &&
                         (wr_ptr[PTR_WIDTH-1:0] == rd_ptr[PTR_WIDTH-1:0]);
    flags.almost_empty = (level <= AE_LVL);
    flags.almost_full  = (level >= AF_LVL);
  end

  assign wr_en = FIFO_WRITE && !flags.full  && !CLR;
  assign rd_en = FIFO_READ  && !flags.empty && !CLR;

  fifo_ptr #(.PTR_WIDTH(PTR_WIDTH)) u_wr_ptr (
    .CLK   (CLK),
    .RST_N (RST_N),
    .clr_i (CLR),
    .inc_i (wr_en),
    .ptr_o (wr_ptr)
  );

  fifo_ptr #(.PTR_WIDTH(PTR_WIDTH)) u_rd_ptr (
    .CLK   (CLK),
    .RST_N (RST_N),
    .clr_i (CLR),
    .inc_i (rd_en),
    .ptr_o (rd_ptr)
  );

  // Storage is deliberately left unreset; pointer reset alone discards contents.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem_q[wr_ptr[PTR_WIDTH-1:0]] <= DATA_IN;
    end
  end

  assign rd_word = mem_q[rd_ptr[PTR_WIDTH-1:0]];

  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (CLR) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else begin
      if (FIFO_WRITE && flags.full)  ovf_d = 1'b1;
      if (FIFO_READ  && flags.empty) unf_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  if (OUT_REG != FIFO_OUT_FALLTHRU) begin : g_out_reg
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  dvalid_q, dvalid_d;

    // rd_en is already masked by CLR, so a flush also drops the valid strobe.
    always_comb begin
      dout_d   = dout_q;
      dvalid_d = rd_en;
      if (rd_en) dout_d = rd_word;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        dout_q   <= '0;
        dvalid_q <= 1'b0;
      end else begin
        dout_q   <= dout_d;
        dvalid_q <= dvalid_d;
      end
    end

    assign DATA_OUT   = dout_q;
    assign DOUT_VALID = dvalid_q;
  end else begin : g_out_comb
    assign DATA_OUT   = rd_word;
    assign DOUT_VALID = !flags.empty;
  end

  assign EMPTY        = flags.empty;
  assign FULL         = flags.full;
  assign ALMOST_EMPTY = flags.almost_empty;
  assign ALMOST_FULL  = flags.almost_full;
  assign LEVEL        = level;
  assign OVERFLOW     = ovf_q;
  assign UNDERFLOW    = unf_q;

endmodule

// File: tb/tb_fifo_buffer_param.sv
// Directed bench for fifo_buffer_param: fall-through and registered-output instances.
module tb_fifo_buffer_param;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        a_clr, a_wr, a_rd;
  logic [31:0] a_din, a_dout;
  logic        a_dv, a_empty, a_full, a_ae, a_af, a_ovf, a_unf;
  logic [2:0]  a_level;

  logic        b_clr, b_wr, b_rd;
  logic [31:0] b_din, b_dout;
  logic        b_dv, b_empty, b_full, b_ae, b_af, b_ovf, b_unf;
  logic [2:0]  b_level;

  int checks   = 0;
  int failures = 0;

  logic [31:0] qa[$];
  logic [31:0] qb[$];

  always #5 clk = ~clk;

  fifo_buffer_param #(.DATA_WIDTH(32), .PTR_WIDTH(2), .OUT_REG(0)) u_dut_a (
    .CLK(clk), .RST_N(rst_n), .CLR(a_clr), .FIFO_WRITE(a_wr), .FIFO_READ(a_rd),
    .DATA_IN(a_din), .DATA_OUT(a_dout), .DOUT_VALID(a_dv), .EMPTY(a_empty),
    .FULL(a_full), .ALMOST_EMPTY(a_ae), .ALMOST_FULL(a_af), .LEVEL(a_level),
    .OVERFLOW(a_ovf), .UNDERFLOW(a_unf)
  );

  fifo_buffer_param #(.DATA_WIDTH(32), .PTR_WIDTH(2), .OUT_REG(1)) u_dut_b (
    .CLK(clk), .RST_N(rst_n), .CLR(b_clr), .FIFO_WRITE(b_wr), .FIFO_READ(b_rd),
    .DATA_IN(b_din), .DATA_OUT(b_dout), .DOUT_VALID(b_dv), .EMPTY(b_empty),
    .FULL(b_full), .ALMOST_EMPTY(b_ae), .ALMOST_FULL(b_af), .LEVEL(b_level),
    .OVERFLOW(b_ovf), .UNDERFLOW(b_unf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    fork
      forever begin
        logic [31:0] exp;
        @(negedge clk);
        if (rst_n) begin
          if (a_rd && !a_empty && !a_clr) begin
            if (qa.size() == 0) begin
              checks++; failures++;
              $display("FAIL sb_a_unexpected: got 0x%0h expected no read", a_dout);
            end else begin
              exp = qa.pop_front();
              chk("sb_a_data", a_dout, exp);
            end
          end
          if (b_dv) begin
            if (qb.size() == 0) begin
              checks++; failures++;
              $display("FAIL sb_b_unexpected: got 0x%0h expected no valid", b_dout);
            end else begin
              exp = qb.pop_front();
              chk("sb_b_data", b_dout, exp);
            end
          end
        end
      end
    join_none

    rst_n = 1'b0;
    a_clr = 0; a_wr = 0; a_rd = 0; a_din = '0;
    b_clr = 0; b_wr = 0; b_rd = 0; b_din = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_empty", 32'(a_empty), 1);
    chk("rst_a_full",  32'(a_full), 0);
    chk("rst_a_ae",    32'(a_ae), 1);
    chk("rst_a_af",    32'(a_af), 0);
    chk("rst_a_level", 32'(a_level), 0);
    chk("rst_a_ovf",   32'(a_ovf), 0);
    chk("rst_a_unf",   32'(a_unf), 0);
    chk("rst_b_dv",    32'(b_dv), 0);
    chk("rst_b_dout",  b_dout, 0);
    rst_n = 1'b1;
    tick();

    // Registered output: one valid pulse, then hold.
    b_wr = 1; b_din = 32'h0000_00FF; tick();
    b_wr = 0; b_rd = 1; qb.push_back(32'h0000_00FF); tick();
    b_rd = 0;
    chk("b_dv_pulse", 32'(b_dv), 1);
    chk("b_dout",     b_dout, 32'h0000_00FF);
    tick();
    chk("b_dv_drop",  32'(b_dv), 0);
    chk("b_dout_hold", b_dout, 32'h0000_00FF);
    chk("b_empty",    32'(b_empty), 1);

    // Fill to full, drain in order.
    for (int unsigned i = 1; i <= 4; i++) begin
      a_wr = 1; a_din = 32'hA5A5_0000 + i; qa.push_back(a_din); tick();
    end
    a_wr = 0;
    chk("full_flag",  32'(a_full), 1);
    chk("full_level", 32'(a_level), 4);
    chk("full_af",    32'(a_af), 1);
    chk("full_ae",    32'(a_ae), 0);
    a_rd = 1; repeat (4) tick(); a_rd = 0;
    chk("drain_empty", 32'(a_empty), 1);
    chk("drain_level", 32'(a_level), 0);

    // Read+write while full.
    for (int unsigned i = 1; i <= 4; i++) begin
      a_wr = 1; a_din = 32'hA5A5_0000 + i; qa.push_back(a_din); tick();
    end
    a_wr = 0;
    chk("refill_full", 32'(a_full), 1);
    a_wr = 1; a_rd = 1; a_din = 32'hDEAD_BEEF; tick();
    a_wr = 0; a_rd = 0;
    chk("rw_full_level", 32'(a_level), 3);
    chk("rw_full_ovf",   32'(a_ovf), 1);
    chk("rw_full_nfull", 32'(a_full), 0);
    chk("rw_full_af",    32'(a_af), 1);

    // Flush overrides concurrent requests.
    a_clr = 1; a_wr = 1; a_rd = 1; a_din = 32'h1234_5678; tick();
    a_clr = 0; a_wr = 0; a_rd = 0;
    qa.delete();
    chk("clr_level", 32'(a_level), 0);
    chk("clr_empty", 32'(a_empty), 1);
    chk("clr_ovf",   32'(a_ovf), 0);
    chk("clr_unf",   32'(a_unf), 0);

    // Read+write while empty.
    a_wr = 1; a_rd = 1; a_din = 32'h5555_0011; qa.push_back(a_din); tick();
    a_wr = 0; a_rd = 0;
    chk("rw_empty_level", 32'(a_level), 1);
    chk("rw_empty_unf",   32'(a_unf), 1);
    chk("rw_empty_ae",    32'(a_ae), 1);
    chk("rw_empty_nempty", 32'(a_empty), 0);
    a_rd = 1; tick(); a_rd = 0;
    chk("unf_sticky", 32'(a_unf), 1);
    chk("rw_empty_drain", 32'(a_empty), 1);

    // Streaming at level 2 across pointer wrap.
    for (int unsigned i = 0; i < 2; i++) begin
      a_wr = 1; a_din = 32'h0000_1000 + i; qa.push_back(a_din); tick();
    end
    chk("stream_ae", 32'(a_ae), 0);
    chk("stream_af", 32'(a_af), 0);
    for (int unsigned i = 0; i < 20; i++) begin
      a_wr = 1; a_rd = 1; a_din = 32'h0000_1002 + i; qa.push_back(a_din); tick();
      chk("stream_level", 32'(a_level), 2);
    end
    a_wr = 0; a_rd = 1; repeat (2) tick(); a_rd = 0;
    chk("stream_empty", 32'(a_empty), 1);

    // Asynchronous reset mid-burst with overflow set.
    for (int unsigned i = 0; i < 4; i++) begin
      a_wr = 1; a_din = 32'hC0DE_0000 + i; qa.push_back(a_din); tick();
    end
    a_din = 32'h0000_0BAD; tick();
    a_wr = 0; a_rd = 1; tick(); a_rd = 0;
    chk("pre_rst_level", 32'(a_level), 3);
    chk("pre_rst_ovf",   32'(a_ovf), 1);
    a_wr = 1; a_din = 32'h7777_7777;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    qa.delete();
    chk("arst_level", 32'(a_level), 0);
    chk("arst_empty", 32'(a_empty), 1);
    chk("arst_full",  32'(a_full), 0);
    chk("arst_ovf",   32'(a_ovf), 0);
    chk("arst_unf",   32'(a_unf), 0);
    chk("arst_b_dout", b_dout, 0);
    a_wr = 0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_empty", 32'(a_empty), 1);

    chk("sb_a_leftover", 32'(qa.size()), 0);
    chk("sb_b_leftover", 32'(qb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
